sram_array_ctrl: RTL and testbench

//  Access controller that drives an array of single-bit SRAM latch cells

---
 rtl/sram_array_ctrl_if.sv | 23 ++
 rtl/sram_array_ctrl.sv | 110 +++++++++++
 tb/tb_sram_array_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sram_array_ctrl_if.sv
// Request/response bus between a bus-side master and the SRAM array controller.
interface sram_array_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_array_ctrl.sv
// Sequences row-select and write-enable waveforms for an array of SRAM latch
// cells from a single-word valid/ready request; every output is registered.
//   state   | meaning
//   IDLE    | ready for a request, array deselected
//   SETUP   | cell_din settling before any row is selected
//   ACCESS  | row selected; write pulse (WR_PULSE cycles) or 1-cycle read
//   RECOVER | row deselected, rsp_valid pulse
module sram_array_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int WR_PULSE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_array_ctrl_if.slave     bus,
  output logic [2**AW-1:0]     cell_sel,
  output logic                 cell_rdwrt,
  output logic [DW-1:0]        cell_din,
  input  logic [DW-1:0]        cell_dout
);
  localparam int CW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       din_q, din_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2**AW-1:0]    sel_q, sel_d;
  logic                rdwrt_q, rdwrt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      sel_q       <= '0;
      rdwrt_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      sel_q       <= sel_d;
      rdwrt_q     <= rdwrt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          we_d   = bus.req_we;
          addr_d = bus.req_addr;
          if (bus.req_we) din_d = bus.req_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(WR_PULSE - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          // write pulse length is a down-counter to terminal count zero
          if (cnt_q == '0) state_d = RECOVER;
          else             cnt_d   = cnt_q - CW'(1);
        end else begin
          rdata_d = cell_dout;
          state_d = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so they register in step with it
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RECOVER);
    rdwrt_d     = !((state_d == ACCESS) && we_d);
    sel_d       = '0;
    if (state_d == ACCESS) sel_d[addr_d] = 1'b1;
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign cell_sel      = sel_q;
  assign cell_rdwrt    = rdwrt_q;
  assign cell_din      = din_q;
endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl with a behavioural model of the cell array.
module tb_sram_array_ctrl;
  logic        clk;
  logic        rst_n;
  logic [15:0] cell_sel;
  logic        cell_rdwrt;
  logic [7:0]  cell_din;
  logic [7:0]  cell_dout;
  logic        mem_load;
  logic [7:0]  mem [16];

  int n_cmp;
  int n_bad;
  int rsp_seen;
  logic       prev_busy;
  logic [7:0] prev_din;

  sram_array_ctrl_if #(.DW(8), .AW(4)) bus ();

  sram_array_ctrl #(.DW(8), .AW(4), .WR_PULSE(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cell_sel   (cell_sel),
    .cell_rdwrt (cell_rdwrt),
    .cell_din   (cell_din),
    .cell_dout  (cell_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cell array: latches din on a selected row while rdwrt is low
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (mem_load) mem[i] <= 8'h10 + 8'(i);
      else if (cell_sel[i] && !cell_rdwrt) mem[i] <= cell_din;
    end
  end

  always_comb begin
    cell_dout = 8'h00;
    for (int i = 0; i < 16; i++)
      if (cell_sel[i]) cell_dout = mem[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // continuous safety checks
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot0_sel", 32'($onehot0(cell_sel)), 32'd1);
      if (!cell_rdwrt)
        check("rdwrt_low_only_in_access", 32'((cell_sel != 16'h0) && !bus.req_ready), 32'd1);
      if (prev_busy && !bus.req_ready)
        check("din_stable_busy", 32'(cell_din), 32'(prev_din));
      if (bus.rsp_valid) rsp_seen++;
    end
    prev_busy = rst_n && !bus.req_ready;
    prev_din  = cell_din;
  end

  // called at a negedge; returns at the negedge where rsp_valid is seen
  task automatic do_req(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                        input logic hold, output int wait_c, output int lat,
                        output int sel_cyc, output int wr_cyc,
                        output logic [15:0] sel_seen, output logic [7:0] din_seen);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    wait_c = 0; lat = 0; sel_cyc = 0; wr_cyc = 0;
    sel_seen = 16'h0; din_seen = 8'h00;
    while (!bus.req_ready && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    if (wait_c >= 20) check("accept_timeout", 32'(wait_c), 32'd0);
    @(posedge clk);
    do begin
      @(negedge clk);
      if (lat == 0) bus.req_valid = hold;
      lat++;
      if (cell_sel != 16'h0) begin sel_cyc++; sel_seen = cell_sel; end
      if (!cell_rdwrt) begin wr_cyc++; din_seen = cell_din; end
    end while (!bus.rsp_valid && lat < 20);
    if (lat >= 20) check("rsp_timeout", 32'(lat), 32'd0);
  endtask

  int         w, l, sc, wc;
  logic [15:0] ss;
  logic [7:0]  ds;

  initial begin
    n_cmp = 0; n_bad = 0; rsp_seen = 0;
    prev_busy = 1'b0; prev_din = 8'h00;
    mem_load = 1'b1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 4'h0; bus.req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_sel", 32'(cell_sel), 32'h0);
    check("rst_rdwrt", 32'(cell_rdwrt), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("rst_din", 32'(cell_din), 32'h0);
    rst_n = 1'b1; mem_load = 1'b0;
    @(negedge clk);

    // write row 3
    do_req(1'b1, 4'd3, 8'hA5, 1'b0, w, l, sc, wc, ss, ds);
    check("wr_wait", 32'(w), 32'd0);
    check("wr_latency", 32'(l), 32'd4);
    check("wr_sel_cycles", 32'(sc), 32'd2);
    check("wr_sel_value", 32'(ss), 32'h0008);
    check("wr_pulse_cycles", 32'(wc), 32'd2);
    check("wr_din", 32'(ds), 32'hA5);
    check("wr_rdata_untouched", 32'(bus.rsp_rdata), 32'h0);
    @(negedge clk);

    // read row 3 back
    do_req(1'b0, 4'd3, 8'h00, 1'b0, w, l, sc, wc, ss, ds);
    check("rd_latency", 32'(l), 32'd3);
    check("rd_sel_cycles", 32'(sc), 32'd1);
    check("rd_sel_value", 32'(ss), 32'h0008);
    check("rd_no_write_pulse", 32'(wc), 32'd0);
    check("rd_data", 32'(bus.rsp_rdata), 32'hA5);
    @(negedge clk);

    // back-to-back with req_valid held: write row 15, then read row 0
    do_req(1'b1, 4'd15, 8'h00, 1'b1, w, l, sc, wc, ss, ds);
    check("b2b_wr_latency", 32'(l), 32'd4);
    check("b2b_wr_sel", 32'(ss), 32'h8000);
    do_req(1'b0, 4'd0, 8'hFF, 1'b0, w, l, sc, wc, ss, ds);
    check("b2b_rd_wait", 32'(w), 32'd1);
    check("b2b_rd_latency", 32'(l), 32'd3);
    check("b2b_rd_sel", 32'(ss), 32'h0001);
    check("b2b_rd_data", 32'(bus.rsp_rdata), 32'h10);
    @(negedge clk);
    do_req(1'b0, 4'd15, 8'h00, 1'b0, w, l, sc, wc, ss, ds);
    check("rd_row15_data", 32'(bus.rsp_rdata), 32'h00);
    @(negedge clk);
    do_req(1'b0, 4'd9, 8'h00, 1'b0, w, l, sc, wc, ss, ds);
    check("rd_row9_data", 32'(bus.rsp_rdata), 32'h19);
    @(negedge clk);
    do_req(1'b1, 4'd5, 8'h5A, 1'b0, w, l, sc, wc, ss, ds);
    check("wr_keeps_rdata", 32'(bus.rsp_rdata), 32'h19);
    @(negedge clk);

    // reset during the ACCESS phase of a write
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd7; bus.req_wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_in_access", 32'(cell_rdwrt), 32'd0);
    rsp_seen = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rdwrt", 32'(cell_rdwrt), 32'd1);
    check("midrst_sel", 32'(cell_sel), 32'h0);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rdata", 32'(bus.rsp_rdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
